// File: rtl/clock_reset_sequencer_if.sv
// clock_reset_sequencer_if: heartbeat inputs, software re-sequence request,
// staged reset requests and status of the clock/reset sequencer.
`timescale 1ns/1ps
interface clock_reset_sequencer_if;
   logic       adc_hb;
   logic       eth_hb;
   logic       sw_reset_req;
   logic       proc_rst_n;
   logic       adc_rst_n;
   logic       eth_rst_n;
   logic       ready;
   logic [2:0] fault;
   logic [2:0] state;

   modport master (
      output adc_hb, eth_hb, sw_reset_req,
      input  proc_rst_n, adc_rst_n, eth_rst_n, ready, fault, state
   );

   modport slave (
      input  adc_hb, eth_hb, sw_reset_req,
      output proc_rst_n, adc_rst_n, eth_rst_n, ready, fault, state
   );
endinterface

// File: rtl/clock_reset_sequencer.sv
// clock_reset_sequencer: qualifies ADC/Eth heartbeats, then releases resets in stages.
// Define CLK_SEQ_AUTO_RECOVER_EN to let FAULT fall back to CHECK after STAGE_DELAY.
`timescale 1ns/1ps
module clock_reset_sequencer #(
   parameter int unsigned CHECK_WINDOW    = 1024,
   parameter int unsigned STAGE_DELAY     = 64,
   parameter int unsigned ADC_MIN         = 120,
   parameter int unsigned ADC_MAX         = 150,
   parameter int unsigned ETH_MIN         = 145,
   parameter int unsigned ETH_MAX         = 175,
   parameter int unsigned TIMEOUT_WINDOWS = 16
) (
   input logic                    clk_processing,
   input logic                    rst_n,
   clock_reset_sequencer_if.slave bus
);
   localparam int unsigned WW = $clog2(CHECK_WINDOW);
   localparam int unsigned TW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
   localparam int unsigned FW = $clog2(TIMEOUT_WINDOWS + 1);

   typedef enum logic [2:0] {
      S_RESET    = 3'd0,
      S_CHECK    = 3'd1,
      S_REL_PROC = 3'd2,
      S_REL_ADC  = 3'd3,
      S_REL_ETH  = 3'd4,
      S_RUN      = 3'd5,
      S_FAULT    = 3'd6
   } state_t;

   state_t        state_q;
   state_t        ns;
   logic [2:0]    adc_sy;
   logic [2:0]    eth_sy;
   logic          adc_edge;
   logic          eth_edge;
   logic [9:0]    adc_cnt;
   logic [9:0]    eth_cnt;
   logic [9:0]    adc_cnt_nx;
   logic [9:0]    eth_cnt_nx;
   logic [WW-1:0] win_q;
   logic          win_end;
   logic          adc_bad;
   logic          eth_bad;
   logic          any_bad;
   logic [TW-1:0] tmr_q;
   logic          tmr_done;
   logic          tmr_clr;
   logic [FW-1:0] fail_q;
   logic [FW-1:0] fail_nx;
   logic [2:0]    fault_q;
   logic [2:0]    fault_nx;
   logic          proc_q;
   logic          adc_q;
   logic          eth_q;
   logic          ready_q;

   // sy[0..1] synchronize, sy[2] delays for toggle (both-edge) detection
   assign adc_edge = adc_sy[2] ^ adc_sy[1];
   assign eth_edge = eth_sy[2] ^ eth_sy[1];
   assign win_end  = (win_q == WW'(CHECK_WINDOW - 1));
   assign tmr_done = (tmr_q == TW'(STAGE_DELAY - 1));

   always_comb begin
      adc_cnt_nx = adc_cnt;
      eth_cnt_nx = eth_cnt;
      if (adc_edge && adc_cnt != 10'd1023) adc_cnt_nx = adc_cnt + 10'd1;
      if (eth_edge && eth_cnt != 10'd1023) eth_cnt_nx = eth_cnt + 10'd1;
   end

   assign adc_bad = (adc_cnt_nx < 10'(ADC_MIN)) || (adc_cnt_nx > 10'(ADC_MAX));
   assign eth_bad = (eth_cnt_nx < 10'(ETH_MIN)) || (eth_cnt_nx > 10'(ETH_MAX));
   assign any_bad = adc_bad || eth_bad;

   always_ff @(posedge clk_processing or negedge rst_n) begin
      if (!rst_n) begin
         adc_sy  <= '0;
         eth_sy  <= '0;
         adc_cnt <= '0;
         eth_cnt <= '0;
         win_q   <= '0;
      end else begin
         adc_sy  <= {adc_sy[1:0], bus.adc_hb};
         eth_sy  <= {eth_sy[1:0], bus.eth_hb};
         win_q   <= win_end ? '0 : win_q + WW'(1);
         adc_cnt <= win_end ? '0 : adc_cnt_nx;
         eth_cnt <= win_end ? '0 : eth_cnt_nx;
      end
   end

   always_comb begin
      ns       = state_q;
      fault_nx = fault_q;
      fail_nx  = fail_q;
      unique case (state_q)
         S_RESET: begin
            if (tmr_done) ns = S_CHECK;
         end
         S_CHECK: begin
            if (win_end) begin
               if (!any_bad) begin
                  ns = proc_q ? S_REL_ADC : S_REL_PROC;
               end else if (fail_q == FW'(TIMEOUT_WINDOWS - 1)) begin
                  fault_nx = fault_q | {1'b1, eth_bad, adc_bad};
                  fail_nx  = '0;
               end else begin
                  fail_nx = fail_q + FW'(1);
               end
            end
         end
         S_REL_PROC, S_REL_ADC, S_REL_ETH: begin
            if (win_end && any_bad) begin
               ns       = S_CHECK;
               fault_nx = fault_q | {1'b0, eth_bad, adc_bad};
            end else if (tmr_done) begin
               if (state_q == S_REL_PROC)     ns = S_REL_ADC;
               else if (state_q == S_REL_ADC) ns = S_REL_ETH;
               else                           ns = S_RUN;
            end
         end
         S_RUN: begin
            if (win_end && any_bad) begin
               ns       = S_FAULT;
               fault_nx = fault_q | {1'b0, eth_bad, adc_bad};
            end
         end
         S_FAULT: begin
`ifdef CLK_SEQ_AUTO_RECOVER_EN
            if (tmr_done) ns = S_CHECK;
`else
            ns = S_FAULT;
`endif
         end
         default: ns = S_RESET;
      endcase
      if (ns != S_CHECK) fail_nx = '0;
      if (bus.sw_reset_req) begin
         ns       = S_RESET;
         fault_nx = '0;
         fail_nx  = '0;
      end
   end

   assign tmr_clr = bus.sw_reset_req || (ns != state_q);

   always_ff @(posedge clk_processing or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RESET;
         fault_q <= '0;
         fail_q  <= '0;
         tmr_q   <= '0;
         proc_q  <= 1'b0;
         adc_q   <= 1'b0;
         eth_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= ns;
         fault_q <= fault_nx;
         fail_q  <= fail_nx;
         tmr_q   <= tmr_clr ? '0 : tmr_q + TW'(1);
         // proc release survives CHECK/FAULT; only RESET pulls it back
         if (ns == S_RESET)         proc_q <= 1'b0;
         else if (ns == S_REL_PROC) proc_q <= 1'b1;
         adc_q   <= (ns == S_REL_ADC) || (ns == S_REL_ETH) || (ns == S_RUN);
         eth_q   <= (ns == S_REL_ETH) || (ns == S_RUN);
         ready_q <= (ns == S_RUN);
      end
   end

   assign bus.proc_rst_n = proc_q;
   assign bus.adc_rst_n  = adc_q;
   assign bus.eth_rst_n  = eth_q;
   assign bus.ready      = ready_q;
   assign bus.fault      = fault_q;
   assign bus.state      = state_q;
endmodule

// File: tb/tb_clock_reset_sequencer.sv
// tb_clock_reset_sequencer: directed vectors for bring-up, clock loss,
// sw re-sequence and timeouts; dut2 uses short windows for REL_* cases.
`timescale 1ns/1ps
module tb_clock_reset_sequencer;
   typedef struct {
      string      name;
      int         at;
      logic [9:0] exp;
   } vec_t;

   logic clk_processing;
   logic rst_n;
   logic rst2_n;
   logic adc_hb;
   logic eth_hb;
   bit   adc_en  = 1'b1;
   bit   eth_en  = 1'b1;
   real  adc_per = 76.2;
   real  eth_per = 64.0;
   int   cyc     = 0;
   int   cyc2    = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   dropped;
   vec_t up [11];

   clock_reset_sequencer_if bus1();
   clock_reset_sequencer_if bus2();

   assign bus1.adc_hb = adc_hb;
   assign bus1.eth_hb = eth_hb;
   assign bus2.adc_hb = adc_hb;
   assign bus2.eth_hb = eth_hb;

   clock_reset_sequencer dut (
      .clk_processing(clk_processing),
      .rst_n         (rst_n),
      .bus           (bus1)
   );

   clock_reset_sequencer #(
      .CHECK_WINDOW   (64),
      .STAGE_DELAY    (128),
      .ADC_MIN        (6),
      .ADC_MAX        (11),
      .ETH_MIN        (8),
      .ETH_MAX        (12),
      .TIMEOUT_WINDOWS(16)
   ) dut2 (
      .clk_processing(clk_processing),
      .rst_n         (rst2_n),
      .bus           (bus2)
   );

   initial begin
      clk_processing = 1'b0;
      forever #5 clk_processing = ~clk_processing;
   end

   // each toggle is one counted edge; a disabled heartbeat parks at 0
   initial begin
      adc_hb = 1'b0;
      forever begin
         #(adc_per);
         adc_hb = adc_en ? ~adc_hb : 1'b0;
      end
   end

   initial begin
      eth_hb = 1'b0;
      forever begin
         #(eth_per);
         eth_hb = eth_en ? ~eth_hb : 1'b0;
      end
   end

   always @(posedge clk_processing or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   always @(posedge clk_processing or negedge rst2_n)
      if (!rst2_n) cyc2 <= 0;
      else         cyc2 <= cyc2 + 1;

   function automatic logic [9:0] pk1();
      return {bus1.proc_rst_n, bus1.adc_rst_n, bus1.eth_rst_n,
              bus1.ready, bus1.fault, bus1.state};
   endfunction

   function automatic logic [9:0] pk2();
      return {bus2.proc_rst_n, bus2.adc_rst_n, bus2.eth_rst_n,
              bus2.ready, bus2.fault, bus2.state};
   endfunction

   task automatic check(input string name, input logic [9:0] got,
                        input logic [9:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %b want %b (p a e rdy fault state)",
                  name, got, want);
      end
   endtask

   task automatic at_cyc(input int n);
      while (cyc < n) @(negedge clk_processing);
   endtask

   task automatic at_cyc2(input int n);
      while (cyc2 < n) @(negedge clk_processing);
   endtask

   task automatic run_up();
      for (int i = 0; i < 11; i++) begin
         at_cyc(up[i].at);
         check(up[i].name, pk1(), up[i].exp);
      end
   endtask

   initial begin
      up[0]  = '{"up_rst",        0, 10'b0000_000_000};
      up[1]  = '{"up_reset_end", 63, 10'b0000_000_000};
      up[2]  = '{"up_check",     64, 10'b0000_000_001};
      up[3]  = '{"up_win_last", 1023, 10'b0000_000_001};
      up[4]  = '{"up_proc",    1024, 10'b1000_000_010};
      up[5]  = '{"up_pre_adc", 1087, 10'b1000_000_010};
      up[6]  = '{"up_adc",     1088, 10'b1100_000_011};
      up[7]  = '{"up_pre_eth", 1151, 10'b1100_000_011};
      up[8]  = '{"up_eth",     1152, 10'b1110_000_100};
      up[9]  = '{"up_pre_rdy", 1215, 10'b1110_000_100};
      up[10] = '{"up_ready",   1216, 10'b1111_000_101};

      rst_n  = 1'b0;
      rst2_n = 1'b0;
      bus1.sw_reset_req = 1'b0;
      bus2.sw_reset_req = 1'b0;
      repeat (5) @(negedge clk_processing);
      check("reset_hold", pk1(), 10'b0);
      rst_n = 1'b1;
      run_up();

      // asynchronous reset from RUN, then a full bring-up again
      at_cyc(1300);
      rst_n = 1'b0;
      #1;
      check("async_rst", pk1(), 10'b0);
      @(negedge clk_processing);
      rst_n = 1'b1;
      run_up();

      // Ethernet clock lost in RUN
      at_cyc(1220);
      eth_en = 1'b0;
      at_cyc(2047);
      check("loss_pre", pk1(), 10'b1111_000_101);
      at_cyc(2048);
      check("loss_fault", pk1(), 10'b1000_010_110);
      at_cyc(2100);
      eth_en = 1'b1;
`ifdef CLK_SEQ_AUTO_RECOVER_EN
      dropped = 1'b0;
      while (!bus1.ready && cyc < 6000) begin
         @(negedge clk_processing);
         if (!bus1.proc_rst_n) dropped = 1'b1;
      end
      check("recover", pk1(), 10'b1111_010_101);
      check("proc_held", {9'b0, dropped}, 10'b0);
`else
      at_cyc(4200);
      check("fault_terminal", pk1(), 10'b1000_010_110);
`endif

      // dut2: sw_reset_req beats a failing window end in REL_ADC
      rst2_n = 1'b1;
      at_cyc2(330);
      adc_en = 1'b0;
      at_cyc2(383);
      check("d2_rel_adc", pk2(), 10'b1100_000_011);
      bus2.sw_reset_req = 1'b1;
      at_cyc2(384);
      bus2.sw_reset_req = 1'b0;
      adc_en = 1'b1;
      check("d2_sw_wins", pk2(), 10'b0000_000_000);
      at_cyc2(575);
      check("d2_reseq_chk", pk2(), 10'b0000_000_001);
      at_cyc2(576);
      check("d2_reseq_proc", pk2(), 10'b1000_000_010);

      // dut2: failing window in REL_ADC returns to CHECK
      at_cyc2(710);
      adc_en = 1'b0;
      at_cyc2(767);
      check("d2_rel_adc2", pk2(), 10'b1100_000_011);
      at_cyc2(768);
      check("d2_rel_fail", pk2(), 10'b1000_001_001);

      // dut2: ADC too fast (12-13 edges per 64-cycle window)
      adc_per = 51.2;
      adc_en  = 1'b1;
      at_cyc2(799);
      bus2.sw_reset_req = 1'b1;
      at_cyc2(800);
      bus2.sw_reset_req = 1'b0;
      check("d2_sw_clear", pk2(), 10'b0000_000_000);
      at_cyc2(1919);
      check("d2_fast_pre", pk2(), 10'b0000_000_001);
      at_cyc2(1920);
      check("d2_fast_to", pk2(), 10'b0000_101_001);

      // dead ADC clock on the default-size block
      adc_per = 76.2;
      adc_en  = 1'b0;
      rst_n   = 1'b0;
      @(negedge clk_processing);
      rst_n = 1'b1;
      at_cyc(64);
      check("dead_check", pk1(), 10'b0000_000_001);
      at_cyc(16383);
      check("dead_pre_to", pk1(), 10'b0000_000_001);
      at_cyc(16384);
      check("dead_timeout", pk1(), 10'b0000_101_001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
